// File: rtl/cnt_stream_pkg.sv
// cnt_stream_pkg
// Shared definitions for the counter-stream checker. These are the
// externally visible state encodings, the lock/unlock defaults and small
// helpers for the error counter.
//
// Contents:
//   state_t             HUNT=0, SYNC=1, LOCKED=2, SLIP=3
//   LOCK_CNT_DEFAULT    consecutive matches needed to declare lock
//   UNLOCK_CNT_DEFAULT  consecutive mismatches needed to drop lock
//   RUN_W               width of the run/miss counters (parameters max 15)
//   sat_inc()           8-bit increment that sticks at 8'hFF
//   is_lock_state()     true in LOCKED or SLIP

package cnt_stream_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_SLIP   = 2'd3
    } state_t;

    localparam int LOCK_CNT_DEFAULT   = 4;
    localparam int UNLOCK_CNT_DEFAULT = 3;
    localparam int RUN_W              = 4;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == ERR_MAX) ? value : value + 8'd1;
    endfunction

    function automatic logic is_lock_state(input state_t s);
        return (s == ST_LOCKED) || (s == ST_SLIP);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync
// Reset synchroniser: assertion passes straight through asynchronously,
// deassertion is retimed through one flop so downstream logic leaves reset
// cleanly on a clock edge. Also used by the counter-source top.
//
// Ports:
//   clk         clock
//   rst_n       raw asynchronous active-low reset
//   rst_n_sync  active-low reset with synchronous release

module rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    // The flop clears the moment rst_n drops and only reports release on the
    // first rising edge after rst_n has gone high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_n_sync <= 1'b0;
        end else begin
            rst_n_sync <= 1'b1;
        end
    end

endmodule

// File: rtl/cnt_stream_checker.sv
// cnt_stream_checker
// Checks a sample stream produced by a free-running 8-bit up-counter at the
// far end. The checker hunts for a starting value, gains confidence over
// LOCK_CNT consecutive matches, then flywheels its expected value while
// locked. Mismatches while locked are counted; UNLOCK_CNT consecutive
// mismatches drop back to hunting.
//
// Parameters:
//   LOCK_CNT    consecutive matches in SYNC needed to lock (1..15)
//   UNLOCK_CNT  consecutive mismatches needed to drop lock (1..15)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (release synchronised)
//   en         din carries a valid sample this cycle
//   din        sample from the far-end counter
//   clr        synchronous clear of err_cnt
//   locked     high in LOCKED or SLIP
//   state      HUNT=0, SYNC=1, LOCKED=2, SLIP=3
//   exp        value expected on the next valid sample
//   err_cnt    saturating count of mismatches seen while locked
//   err_pulse  one-cycle strobe for every counted mismatch

module cnt_stream_checker
    import cnt_stream_pkg::*;
#(
    parameter int LOCK_CNT   = LOCK_CNT_DEFAULT,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] din,
    input  logic       clr,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] exp,
    output logic [7:0] err_cnt,
    output logic       err_pulse
);

    localparam logic [RUN_W-1:0] LOCK_TGT   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] UNLOCK_TGT = RUN_W'(UNLOCK_CNT);

    logic             rst_int_n;
    state_t           state_q;
    logic [7:0]       exp_q;
    logic [7:0]       err_q;
    logic             pulse_q;
    logic             locked_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] miss_q;

    logic             match;
    logic [RUN_W-1:0] run_inc;
    logic [RUN_W-1:0] miss_inc;

    rst_sync u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_n_sync (rst_int_n)
    );

    // run and miss never exceed 14 before being compared, so the +1 cannot wrap.
    assign match    = en && (din == exp_q);
    assign run_inc  = run_q + RUN_W'(1);
    assign miss_inc = miss_q + RUN_W'(1);

    // Tracking FSM. The expected value keeps counting through single
    // mismatches while locked so a lone corrupted sample does not cost lock.
    // The clear is applied last so it overrides an increment in the same cycle
    // while the strobe for that mismatch is still raised.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= ST_HUNT;
            exp_q    <= 8'd0;
            err_q    <= 8'd0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
            run_q    <= '0;
            miss_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_HUNT: begin
                        exp_q    <= din + 8'd1;
                        run_q    <= '0;
                        state_q  <= ST_SYNC;
                        locked_q <= 1'b0;
                    end
                    ST_SYNC: begin
                        if (match) begin
                            exp_q <= exp_q + 8'd1;
                            if (run_inc == LOCK_TGT) begin
                                run_q    <= '0;
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                run_q <= run_inc;
                            end
                        end else begin
                            exp_q <= din + 8'd1;
                            run_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        exp_q <= exp_q + 8'd1;
                        if (!match) begin
                            err_q   <= sat_inc(err_q);
                            pulse_q <= 1'b1;
                            miss_q  <= RUN_W'(1);
                            state_q <= ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        if (match) begin
                            exp_q   <= exp_q + 8'd1;
                            miss_q  <= '0;
                            state_q <= ST_LOCKED;
                        end else begin
                            err_q   <= sat_inc(err_q);
                            pulse_q <= 1'b1;
                            // >= lets UNLOCK_CNT=1 still take the LOCKED->SLIP->HUNT path.
                            if (miss_inc >= UNLOCK_TGT) begin
                                miss_q   <= '0;
                                state_q  <= ST_HUNT;
                                locked_q <= 1'b0;
                            end else begin
                                miss_q <= miss_inc;
                                exp_q  <= exp_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            if (clr) begin
                err_q <= 8'd0;
            end
        end
    end

    assign state     = state_q;
    assign exp       = exp_q;
    assign err_cnt   = err_q;
    assign err_pulse = pulse_q;
    assign locked    = locked_q;

endmodule

// File: doc/cnt_stream_checker.md
CNT_STREAM_CHECKER -- requirements
Module: cnt_stream_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4: consecutive matches required to declare lock (range 1..15).
REQ-002 The block SHALL have parameter UNLOCK_CNT, default 3: consecutive mismatches required to drop lock (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: din is a valid sample in this cycle.
REQ-006 The block SHALL have port din, input, 8 bits: sample from the far-end free-running 8-bit up-counter.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of err_cnt.
REQ-008 The block SHALL have port locked, output, 1 bit: high in LOCKED or SLIP.
REQ-009 The block SHALL have port state, output, 2 bits: HUNT=0, SYNC=1, LOCKED=2, SLIP=3.
REQ-010 The block SHALL have port exp, output, 8 bits: value expected on the next valid sample.
REQ-011 The block SHALL have port err_cnt, output, 8 bits: saturating mismatch count.
REQ-012 The block SHALL have port err_pulse, output, 1 bit: one-cycle strobe per counted mismatch.

Function
REQ-013 Comparison SHALL be against the current-cycle din; every output SHALL be registered and reflect a sample one clock edge after that sample's edge.
REQ-014 Cycles with en=0 SHALL leave state, exp, err_cnt and the run counters unchanged, and SHALL force err_pulse=0.
REQ-015 match SHALL be defined as en and din==exp; all exp arithmetic SHALL be modulo 256, so 8'hFF followed by 8'h00 is a match.
REQ-016 HUNT: on a valid sample, exp<=din+1, run<=0, next state SYNC.
REQ-017 SYNC on match: exp<=exp+1 and run<=run+1; when run+1==LOCK_CNT, next state LOCKED and run<=0.
REQ-018 SYNC on mismatch: exp<=din+1, run<=0, stay in SYNC, and err_cnt SHALL NOT change.
REQ-019 LOCKED on match: exp<=exp+1.
REQ-020 LOCKED on mismatch: exp<=exp+1 (flywheel), err_cnt increments, err_pulse=1, miss<=1, next state SLIP.
REQ-021 SLIP on match: exp<=exp+1, miss<=0, next state LOCKED.
REQ-022 SLIP on mismatch: err_cnt increments and err_pulse=1.
REQ-023 SLIP on mismatch: if miss+1==UNLOCK_CNT, next state HUNT and miss<=0; otherwise miss<=miss+1 and exp<=exp+1.
REQ-024 err_cnt SHALL saturate at 8'hFF; at saturation err_pulse SHALL still assert on each mismatch.
REQ-025 clr=1 SHALL set err_cnt<=0 at the next edge; clr SHALL take priority over a simultaneous increment, and err_pulse still asserts for that mismatch.
REQ-026 clr SHALL NOT affect state, exp or the run counters.
REQ-027 With LOCK_CNT=1, the first match in SYNC SHALL enter LOCKED.
REQ-028 With UNLOCK_CNT=1, the first mismatch in LOCKED SHALL enter SLIP, and the next mismatch SHALL enter HUNT.

Reset
REQ-029 rst_n low SHALL asynchronously force state=HUNT, exp=0, err_cnt=0, err_pulse=0, locked=0, run=0, miss=0.
REQ-030 rst_n deassertion SHALL be synchronised through one internal flop, so the first sample the block can accept is on the second rising edge after rst_n rises.
REQ-031 Reset asserted mid-stream SHALL abandon lock immediately, with no err_pulse.

Structure
REQ-032 State encodings and parameter defaults SHALL live in a shared package, cnt_stream_pkg.
REQ-033 The reset synchroniser SHALL be a sub-module, rst_sync, shared with the counter-source top.
REQ-034 There SHALL be no other sub-modules.

Verification
REQ-035 Bench SHALL cover: reset, then en=1 with din=10,11,12,13,14 -> state SYNC after 10; LOCKED after 14; exp=15; err_cnt=0.
REQ-036 Bench SHALL cover: locked, then din sequence FE,FF,00,01 -> remains LOCKED; no err_pulse; exp=02.
REQ-037 Bench SHALL cover: locked with exp=20, then din=55 followed by din=21 -> SLIP with err_cnt=1 and one err_pulse; then LOCKED; exp=22.
REQ-038 Bench SHALL cover: locked, then 3 consecutive wrong samples -> err_cnt=3, 3 pulses, state HUNT; then a fresh sequence relocks after 1+LOCK_CNT samples.
REQ-039 Bench SHALL cover: err_cnt=255 plus a further mismatch -> err_cnt stays 255 with a pulse; then clr on a mismatch cycle -> err_cnt=0.
REQ-040 Bench SHALL cover: en toggled 1,0,0,1 while LOCKED with din held stale during en=0 -> no errors, and exp advances only on en=1 cycles.
